ps2_rx_frame: RTL

//  Host-side PS/2 receiver: deserialises 11-bit device-to-host frames
//  (start, 8 data LSB-first, odd parity, stop) from keyboard clock/data lines.

---
 rtl/ps2_rx_frame_pkg.sv | 5 +
 rtl/ps2_rx_frame_line_filter.sv | 31 +++
 rtl/ps2_rx_frame.sv | 82 ++++++++
 3 files changed

// File: rtl/ps2_rx_frame_pkg.sv
// ps2_rx_frame_pkg: shared PS/2 receiver state encodings and frame constants
package ps2_rx_frame_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  localparam int PS2_FRAME_BITS = 11;
endpackage

// File: rtl/ps2_rx_frame_line_filter.sv
// ps2_rx_frame_line_filter: synchroniser plus debounce with registered falling-edge strobe
module ps2_rx_frame_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic fall
);
  localparam int CW = FILTER_LEN > 1 ? $clog2(FILTER_LEN) : 1;
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  logic s, flip;
  assign s = sync[SYNC_STAGES-1];
  assign flip = (s != level) && (cnt == CW'(FILTER_LEN - 1));
  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= '1;
      level <= 1'b1;
      cnt   <= '0;
      fall  <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], din};
      level <= flip ? s : level;
      cnt   <= (s == level || flip) ? '0 : cnt + 1'b1;
      fall  <= flip && !s;
    end
  end
endmodule

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: host-side PS/2 frame receiver with parity, framing and timeout checks
module ps2_rx_frame
  import ps2_rx_frame_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rx_en,
  output logic [7:0] data,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       timeout,
  output logic       busy
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state, state_n;
  logic fall, sd, done, to;
  logic unused_clk_level, unused_data_fall;
  logic [2:0] bitcnt;
  logic [7:0] shreg;
  logic par;
  logic [TW-1:0] tcnt;
  ps2_rx_frame_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_clk (
    .clk(clk), .reset(reset), .din(ps2_clk), .level(unused_clk_level), .fall(fall)
  );
  ps2_rx_frame_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(1)) u_data (
    .clk(clk), .reset(reset), .din(ps2_data), .level(sd), .fall(unused_data_fall)
  );
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    done = 1'b0;
    to = 1'b0;
    case (state)
      IDLE:    state_n = (fall && rx_en && !sd) ? DATA : IDLE;
      DATA:    state_n = (fall && bitcnt == 3'd7) ? PARITY : DATA;
      PARITY:  state_n = fall ? STOP : PARITY;
      default: begin
        state_n = fall ? IDLE : STOP;
        done = fall;
      end
    endcase
    // a fall landing on the expiry cycle wins, so valid and timeout stay exclusive
    if (state != IDLE && !fall && tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
      state_n = IDLE;
      to = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bitcnt     <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      tcnt       <= '0;
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state   <= state_n;
      bitcnt  <= state == IDLE ? '0 : (state == DATA && fall) ? bitcnt + 1'b1 : bitcnt;
      tcnt    <= (state == IDLE || fall) ? '0 : tcnt + 1'b1;
      valid   <= done;
      timeout <= to;
      if (state == DATA && fall) shreg[bitcnt] <= sd;
      if (state == PARITY && fall) par <= sd;
      if (done) begin
        data       <= shreg;
        parity_err <= ~(^shreg ^ par);
        frame_err  <= ~sd;
      end
    end
  end
endmodule
